// File: rtl/cve2_sim_timer_pkg.sv
// cve2_sim_timer_pkg: register map, CTRL layout and reset constants for the simulation machine timer.
package cve2_sim_timer_pkg;

   localparam logic [7:0] TimerMtimeLo    = 8'd0;
   localparam logic [7:0] TimerMtimeHi    = 8'd1;
   localparam logic [7:0] TimerMtimecmpLo = 8'd2;
   localparam logic [7:0] TimerMtimecmpHi = 8'd3;
   localparam logic [7:0] TimerCtrl       = 8'd4;
   localparam logic [7:0] TimerPrescale   = 8'd5;

   localparam int unsigned CtrlEnableBit = 0;

   localparam logic [63:0] MtimecmpReset = 64'hFFFF_FFFF_FFFF_FFFF;

   function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wdata,
                                            input logic [3:0] be);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) res[8*i +: 8] = be[i] ? wdata[8*i +: 8] : old[8*i +: 8];
      return res;
   endfunction

endpackage

// File: rtl/cve2_sim_timer_prescaler.sv
// cve2_sim_timer_prescaler: divides the clock by (prescale + 1) while enabled, emitting a one-cycle tick.
module cve2_sim_timer_prescaler
   import cve2_sim_timer_pkg::*;
#(
   parameter int unsigned Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             enable,
   input  logic             clear,
   input  logic [Width-1:0] prescale,
   output logic             tick
);

   logic [Width-1:0] count;

   assign tick = enable && count == prescale;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) count <= '0;
      else if (clear || tick) count <= '0;
      else if (enable) count <= count + 1'b1;
   end

endmodule

// File: rtl/cve2_sim_timer.sv
// cve2_sim_timer: memory-mapped mtime/mtimecmp machine timer for the simulation bus.
// Every request gets a response the next cycle; timer_irq_o is a registered level.
module cve2_sim_timer
   import cve2_sim_timer_pkg::*;
#(
   parameter int unsigned              PrescaleWidth = 16,
   parameter logic [PrescaleWidth-1:0] PrescaleReset = '0,
   parameter logic                     EnableReset   = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        dev_req_i,
   input  logic        dev_we_i,
   input  logic [3:0]  dev_be_i,
   input  logic [31:0] dev_addr_i,
   input  logic [31:0] dev_wdata_i,
   output logic        dev_rvalid_o,
   output logic [31:0] dev_rdata_o,
   output logic        dev_err_o,
   output logic        timer_irq_o
);

   logic [7:0]               idx;
   logic                     idx_ok, wr, rd;
   logic                     wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_prescale;
   logic [63:0]              mtime, mtime_d, mtimecmp, mtimecmp_d;
   logic                     enable, enable_d, tick;
   logic [PrescaleWidth-1:0] prescale, prescale_d;
   logic [31:0]              prescale_wr, rdata_d;
   logic                     unused;

   assign idx    = dev_addr_i[9:2];
   assign idx_ok = idx <= TimerPrescale;
   assign wr     = dev_req_i & dev_we_i & idx_ok;
   assign rd     = dev_req_i & ~dev_we_i & idx_ok;

   assign wr_mtime_lo = wr && idx == TimerMtimeLo;
   assign wr_mtime_hi = wr && idx == TimerMtimeHi;
   assign wr_cmp_lo   = wr && idx == TimerMtimecmpLo;
   assign wr_cmp_hi   = wr && idx == TimerMtimecmpHi;
   assign wr_ctrl     = wr && idx == TimerCtrl;
   assign wr_prescale = wr && idx == TimerPrescale;

   cve2_sim_timer_prescaler #(
      .Width(PrescaleWidth)
   ) u_prescaler (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .enable  (enable),
      .clear   (wr_prescale),
      .prescale(prescale),
      .tick    (tick)
   );

   // A software write to either half of mtime swallows the whole 64-bit increment.
   assign mtime_d = wr_mtime_lo ? {mtime[63:32], be_merge(mtime[31:0], dev_wdata_i, dev_be_i)} :
                    wr_mtime_hi ? {be_merge(mtime[63:32], dev_wdata_i, dev_be_i), mtime[31:0]} :
                    tick        ? mtime + 64'd1 : mtime;

   assign mtimecmp_d = wr_cmp_lo ? {mtimecmp[63:32], be_merge(mtimecmp[31:0], dev_wdata_i, dev_be_i)} :
                       wr_cmp_hi ? {be_merge(mtimecmp[63:32], dev_wdata_i, dev_be_i), mtimecmp[31:0]} :
                       mtimecmp;

   assign enable_d    = wr_ctrl && dev_be_i[CtrlEnableBit/8] ? dev_wdata_i[CtrlEnableBit] : enable;
   assign prescale_wr = be_merge(32'(prescale), dev_wdata_i, dev_be_i);
   assign prescale_d  = wr_prescale ? prescale_wr[PrescaleWidth-1:0] : prescale;
   assign unused      = ^{dev_addr_i[31:10], dev_addr_i[1:0], prescale_wr[31:PrescaleWidth]};

   always_comb begin
      rdata_d = '0;
      case (idx)
         TimerMtimeLo:    rdata_d = mtime[31:0];
         TimerMtimeHi:    rdata_d = mtime[63:32];
         TimerMtimecmpLo: rdata_d = mtimecmp[31:0];
         TimerMtimecmpHi: rdata_d = mtimecmp[63:32];
         TimerCtrl:       rdata_d = 32'(enable) << CtrlEnableBit;
         TimerPrescale:   rdata_d = 32'(prescale);
         default:         rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mtime        <= '0;
         mtimecmp     <= MtimecmpReset;
         enable       <= EnableReset;
         prescale     <= PrescaleReset;
         dev_rvalid_o <= 1'b0;
         dev_rdata_o  <= '0;
         dev_err_o    <= 1'b0;
         timer_irq_o  <= 1'b0;
      end else begin
         mtime        <= mtime_d;
         mtimecmp     <= mtimecmp_d;
         enable       <= enable_d;
         prescale     <= prescale_d;
         dev_rvalid_o <= dev_req_i;
         dev_rdata_o  <= rd ? rdata_d : '0;
         dev_err_o    <= dev_req_i & ~idx_ok;
         timer_irq_o  <= mtime_d >= mtimecmp_d;
      end
   end

endmodule
